// File: rtl/rd53_sync_afe_tot_model.sv
// Clocked model of an RD53 synchronous AFE: per-channel charge integration, threshold and ToT,
// with an auto-zero sequencer that blanks every channel. `RD53_AFE_GAIN_SEL_EN enables the {S1,S0} gain.
module rd53_sync_afe_tot_model #(
  parameter int NCH       = 4,
  parameter int AMP_W     = 8,
  parameter int TOT_W     = 4,
  parameter int AZ_LEN    = 4,
  parameter int AZ_SETTLE = 2,
  parameter int AZ_PERIOD = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   POWER_DOWN,
  input  logic [NCH-1:0]         HIT_VALID,
  input  logic [NCH*AMP_W-1:0]   HIT_AMP,
  input  logic [AMP_W-1:0]       VTH,
  input  logic [3:0]             ICTRL_TOT,
  input  logic                   S0,
  input  logic                   S1,
  input  logic                   AZ_REQ,
  output logic                   PHI_AZ,
  output logic                   AZ_BUSY,
  output logic [NCH-1:0]         DISC_OUT,
  output logic [NCH-1:0]         TOT_VALID,
  output logic [NCH*TOT_W-1:0]   TOT_OUT
);

  localparam int Q_W     = AMP_W + 2;
  localparam int SUM_W   = AMP_W + 4;
  localparam int CNT_MAX = (AZ_LEN > AZ_SETTLE) ? AZ_LEN : AZ_SETTLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMR_W   = (AZ_PERIOD > 1) ? $clog2(AZ_PERIOD) : 1;

  localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'((AZ_LEN > 0) ? AZ_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((AZ_SETTLE > 0) ? AZ_SETTLE - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((AZ_PERIOD > 0) ? AZ_PERIOD - 1 : 0);
  localparam logic [Q_W-1:0]   Q_MAX    = '1;
  localparam logic [TOT_W-1:0] TOT_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_AZ, ST_SETTLE} az_state_e;

  az_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               az_start;
  logic               period_hit;
  logic               blank;

  logic [Q_W-1:0]     q_q   [NCH];
  logic [Q_W-1:0]     q_d   [NCH];
  logic [SUM_W-1:0]   sum   [NCH];
  logic [TOT_W-1:0]   run_q [NCH];
  logic [TOT_W-1:0]   run_d [NCH];
  logic [TOT_W-1:0]   tot_q [NCH];
  logic [TOT_W-1:0]   tot_d [NCH];
  logic [NCH-1:0]     disc_q, disc_d;
  logic [NCH-1:0]     tv_q, tv_d;
  logic [4:0]         dis;
  logic [1:0]         gain_sh;

`ifdef RD53_AFE_GAIN_SEL_EN
  assign gain_sh = {S1, S0};
`else
  logic gain_sel_unused;
  assign gain_sel_unused = S0 ^ S1;
  assign gain_sh         = 2'd0;
`endif

  assign dis        = {1'b0, ICTRL_TOT} + 5'd1;
  assign period_hit = (AZ_PERIOD != 0) && (tmr_q == TMR_LAST);

  // Power-down overrides everything and parks the sequencer in IDLE with the timer cleared.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    az_start = 1'b0;
    if (POWER_DOWN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (AZ_REQ || period_hit) begin
            az_start = 1'b1;
            state_d  = ST_AZ;
            cnt_d    = '0;
            tmr_d    = '0;
          end else if (AZ_PERIOD != 0) begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_AZ: begin
          if (cnt_q == AZ_LAST) begin
            cnt_d   = '0;
            state_d = (AZ_SETTLE == 0) ? ST_IDLE : ST_SETTLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Entering AZ blanks the same edge, so a coincident hit is dropped.
  assign blank = POWER_DOWN | (state_q != ST_IDLE) | az_start;

  always_comb begin
    disc_d = '0;
    tv_d   = '0;
    for (int k = 0; k < NCH; k++) begin
      sum[k]   = SUM_W'(q_q[k]) + (SUM_W'(HIT_AMP[k*AMP_W +: AMP_W]) << gain_sh);
      q_d[k]   = q_q[k];
      run_d[k] = run_q[k];
      tot_d[k] = tot_q[k];
      if (blank) begin
        q_d[k]   = '0;
        run_d[k] = '0;
      end else begin
        if (HIT_VALID[k]) begin
          q_d[k] = (sum[k] > SUM_W'(Q_MAX)) ? Q_MAX : sum[k][Q_W-1:0];
        end else begin
          q_d[k] = (q_q[k] > Q_W'(dis)) ? (q_q[k] - Q_W'(dis)) : '0;
        end
        disc_d[k] = (q_d[k] > Q_W'(VTH));
        // The count includes the current high cycle, so the falling edge reports run+1.
        if (disc_q[k]) begin
          if (!disc_d[k]) begin
            tot_d[k] = (run_q[k] == TOT_MAX) ? TOT_MAX : run_q[k] + TOT_W'(1);
            tv_d[k]  = 1'b1;
            run_d[k] = '0;
          end else begin
            run_d[k] = (run_q[k] == TOT_MAX) ? TOT_MAX : run_q[k] + TOT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      disc_q  <= '0;
      tv_q    <= '0;
      for (int k = 0; k < NCH; k++) begin
        q_q[k]   <= '0;
        run_q[k] <= '0;
        tot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      disc_q  <= disc_d;
      tv_q    <= tv_d;
      for (int k = 0; k < NCH; k++) begin
        q_q[k]   <= q_d[k];
        run_q[k] <= run_d[k];
        tot_q[k] <= tot_d[k];
      end
    end
  end

  assign PHI_AZ    = (state_q == ST_AZ);
  assign AZ_BUSY   = (state_q != ST_IDLE);
  assign DISC_OUT  = disc_q;
  assign TOT_VALID = tv_q;

  for (genvar g = 0; g < NCH; g++) begin : g_tot
    assign TOT_OUT[g*TOT_W +: TOT_W] = tot_q[g];
  end

endmodule

// File: tb/tb_rd53_sync_afe_tot_model.sv
// Bench for rd53_sync_afe_tot_model: directed scenarios plus randomized traffic against a charge/ToT model.
`timescale 1ns/1ps
module tb_rd53_sync_afe_tot_model;
  localparam int NCH = 4, AMP_W = 8, TOT_W = 4, AZ_LEN = 4, AZ_SETTLE = 2;
  localparam int Q_MAX = 1023, TOT_MAX = 15;
`ifdef RD53_AFE_GAIN_SEL_EN
  localparam bit GAIN_EN = 1'b1;
`else
  localparam bit GAIN_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, rst_p = 1'b1;
  logic pd = 1'b0, az_req = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [NCH-1:0] hit_valid = '0;
  logic [NCH*AMP_W-1:0] hit_amp = '0;
  logic [AMP_W-1:0] vth = 8'd20;
  logic [3:0] ictrl = 4'd4;

  logic PHI_AZ, AZ_BUSY;
  logic [NCH-1:0] DISC_OUT, TOT_VALID;
  logic [NCH*TOT_W-1:0] TOT_OUT;
  logic phi_p, busy_p;
  logic [NCH-1:0] disc_p, tv_p;
  logic [NCH*TOT_W-1:0] tot_p;

  always #5 clk = ~clk;

  rd53_sync_afe_tot_model #(.NCH(NCH), .AMP_W(AMP_W), .TOT_W(TOT_W), .AZ_LEN(AZ_LEN),
                            .AZ_SETTLE(AZ_SETTLE), .AZ_PERIOD(0)) dut (
    .CLK(clk), .RST(rst), .POWER_DOWN(pd), .HIT_VALID(hit_valid), .HIT_AMP(hit_amp),
    .VTH(vth), .ICTRL_TOT(ictrl), .S0(s0), .S1(s1), .AZ_REQ(az_req),
    .PHI_AZ(PHI_AZ), .AZ_BUSY(AZ_BUSY), .DISC_OUT(DISC_OUT), .TOT_VALID(TOT_VALID), .TOT_OUT(TOT_OUT));

  rd53_sync_afe_tot_model #(.NCH(NCH), .AMP_W(AMP_W), .TOT_W(TOT_W), .AZ_LEN(AZ_LEN),
                            .AZ_SETTLE(AZ_SETTLE), .AZ_PERIOD(50)) dut_p (
    .CLK(clk), .RST(rst_p), .POWER_DOWN(1'b0), .HIT_VALID('0), .HIT_AMP('0),
    .VTH(8'd20), .ICTRL_TOT(4'd4), .S0(1'b0), .S1(1'b0), .AZ_REQ(1'b0),
    .PHI_AZ(phi_p), .AZ_BUSY(busy_p), .DISC_OUT(disc_p), .TOT_VALID(tv_p), .TOT_OUT(tot_p));

  int checks = 0, failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer charge, remaining-blank-cycle count, unsaturated run length.
  int m_q [NCH];
  int m_run [NCH];
  int m_tot [NCH];
  int m_busy;
  logic [NCH-1:0] m_disc, m_tv;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0;
        m_disc = '0;
        m_tv   = '0;
        for (int k = 0; k < NCH; k++) begin
          m_q[k] = 0; m_run[k] = 0; m_tot[k] = 0;
        end
      end else begin
        bit blank;
        bit nd;
        int gain;
        int a;
        blank = pd || (m_busy > 0) || az_req;
        if (pd) m_busy = 0;
        else if (m_busy > 0) m_busy = m_busy - 1;
        else if (az_req) m_busy = AZ_LEN + AZ_SETTLE;
        gain = GAIN_EN ? (1 << {s1, s0}) : 1;
        for (int k = 0; k < NCH; k++) begin
          m_tv[k] = 1'b0;
          if (blank) begin
            m_q[k] = 0; m_run[k] = 0; nd = 1'b0;
          end else begin
            a = int'(hit_amp[k*AMP_W +: AMP_W]);
            if (hit_valid[k]) m_q[k] = (m_q[k] + a * gain > Q_MAX) ? Q_MAX : m_q[k] + a * gain;
            else m_q[k] = (m_q[k] - (int'(ictrl) + 1) < 0) ? 0 : m_q[k] - (int'(ictrl) + 1);
            nd = (m_q[k] > int'(vth));
            if (m_disc[k]) m_run[k]++;
            if (m_disc[k] && !nd) begin
              m_tot[k] = (m_run[k] > TOT_MAX) ? TOT_MAX : m_run[k];
              m_tv[k] = 1'b1;
              m_run[k] = 0;
            end
          end
          m_disc[k] = nd;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic [NCH*TOT_W-1:0] etot;
        for (int k = 0; k < NCH; k++) etot[k*TOT_W +: TOT_W] = m_tot[k][TOT_W-1:0];
        chk("disc_out", DISC_OUT, m_disc);
        chk("tot_valid", TOT_VALID, m_tv);
        chk("tot_out", TOT_OUT, etot);
        chk("phi_az", PHI_AZ, m_busy > AZ_SETTLE);
        chk("az_busy", AZ_BUSY, m_busy > 0);
      end
    end
  end

  task automatic clear_all();
    hit_valid = '0; pd = 1'b0; az_req = 1'b1;
    tick();
    az_req = 1'b0;
    repeat (7) tick();
  endtask

  task automatic run_tot8(input int ch);
    vth = 8'd20; ictrl = 4'd4;
    hit_valid = '0; hit_valid[ch] = 1'b1; hit_amp[ch*AMP_W +: AMP_W] = 8'd60;
    tick();
    hit_valid = '0;
    for (int i = 1; i <= 12; i++) begin
      chk("tot8_disc_window", DISC_OUT[ch], i <= 8);
      chk("tot8_valid_cycle", TOT_VALID[ch], i == 9);
      if (i == 9) chk("tot8_value", TOT_OUT[ch*TOT_W +: TOT_W], 8);
      tick();
    end
  endtask

  initial begin
    int first_rise, last_rise, nr, n, ntv, nd, nphi, nbusy;
    bit prev;

    repeat (3) @(posedge clk);
    #1;
    // Periodic auto-zero on the second instance.
    rst_p = 1'b0;
    prev = 1'b0; first_rise = -1; last_rise = -1; nr = 0; nphi = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (phi_p) nphi++;
      if (phi_p && !prev) begin
        if (last_rise >= 0) chk("az_period_gap", c - last_rise, 56);
        else first_rise = c;
        last_rise = c;
        nr++;
      end
      prev = phi_p;
    end
    chk("az_period_first", first_rise, 49);
    chk("az_period_rises", nr, 5);
    chk("az_period_phi_cycles", nphi, 20);

    rst = 1'b0;
    chk("reset_state", {DISC_OUT, TOT_VALID, TOT_OUT, PHI_AZ, AZ_BUSY}, 0);
    cmp_en = 1'b1;
    tick();

    // Nominal pulse on ch0.
    clear_all();
    run_tot8(0);

    // Back-to-back full-scale hits, slowest discharge: ToT saturates, charge keeps its value.
    clear_all();
    vth = 8'd20; ictrl = 4'd0;
    hit_valid = 4'b0100; hit_amp[2*AMP_W +: AMP_W] = 8'd255;
    tick();
    chk("sat_first_disc", DISC_OUT[2], 1);
    tick();
    hit_valid = '0;
    n = 1;
    while (DISC_OUT[2] && n < 1000) begin
      n++;
      tick();
    end
    chk("sat_disc_len", n, 491);
    chk("sat_tot_valid", TOT_VALID[2], 1);
    chk("sat_tot_out", TOT_OUT[2*TOT_W +: TOT_W], TOT_MAX);

    // Auto-zero request in the middle of an open pulse; a second request while busy is ignored.
    clear_all();
    vth = 8'd20; ictrl = 4'd4;
    hit_valid = 4'b0010; hit_amp[1*AMP_W +: AMP_W] = 8'd100;
    tick();
    hit_valid = '0;
    tick(); tick();
    chk("az_pre_disc", DISC_OUT[1], 1);
    az_req = 1'b1;
    tick();
    az_req = 1'b0;
    nphi = 0; nbusy = 0; nd = 0; ntv = 0;
    for (int j = 1; j <= 20; j++) begin
      nphi += int'(PHI_AZ); nbusy += int'(AZ_BUSY);
      nd += int'(DISC_OUT[1]); ntv += int'(TOT_VALID[1]);
      az_req = (j == 2);
      tick();
    end
    az_req = 1'b0;
    chk("az_phi_cycles", nphi, 4);
    chk("az_busy_cycles", nbusy, 6);
    chk("az_disc_blank", nd, 0);
    chk("az_no_tot_valid", ntv, 0);

    // Power-down during a pulse, then reset in the middle of another.
    clear_all();
    hit_valid = 4'b0001; hit_amp[0 +: AMP_W] = 8'd100;
    tick();
    hit_valid = '0;
    tick();
    chk("pd_pre_disc", DISC_OUT[0], 1);
    pd = 1'b1;
    nd = 0; ntv = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 1) pd = 1'b0;
      nd += int'(DISC_OUT[0]); ntv += int'(TOT_VALID[0]);
    end
    chk("pd_disc_blank", nd, 0);
    chk("pd_no_tot_valid", ntv, 0);

    hit_valid = 4'b1000; hit_amp[3*AMP_W +: AMP_W] = 8'd100;
    tick();
    hit_valid = '0;
    tick();
    chk("rst_pre_disc", DISC_OUT[3], 1);
    #2 rst = 1'b1;
    #1 chk("rst_outputs", {DISC_OUT, TOT_VALID, TOT_OUT, PHI_AZ, AZ_BUSY}, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    ntv = 0;
    for (int j = 0; j < 15; j++) begin
      tick();
      ntv += int'(TOT_VALID);
    end
    chk("rst_no_tot_valid", ntv, 0);
    run_tot8(3);

    // Gain x4 pushes a small hit over threshold only when gain selection is built in.
    clear_all();
    s1 = 1'b1; s0 = 1'b0; vth = 8'd30;
    hit_valid = 4'b0001; hit_amp[0 +: AMP_W] = 8'd10;
    tick();
    hit_valid = '0;
    chk("gain_disc", DISC_OUT[0], GAIN_EN);
    s1 = 1'b0;
    repeat (5) tick();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      int hp;
      hp = ((c % 500) < 20) ? 1 : 7;
      hit_valid = '0;
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, hp) == 0) begin
          hit_valid[k] = 1'b1;
          hit_amp[k*AMP_W +: AMP_W] = AMP_W'($urandom_range(0, 255));
        end
      end
      az_req = ($urandom_range(0, 79) == 0);
      pd = ($urandom_range(0, 99) == 0);
      if ((c % 64) == 0) begin
        vth = AMP_W'($urandom_range(0, 120));
        ictrl = 4'($urandom_range(0, 15));
        s0 = 1'($urandom_range(0, 1));
        s1 = 1'($urandom_range(0, 1));
      end
      if (c == 2000) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
      end
      tick();
    end
    hit_valid = '0; az_req = 1'b0; pd = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
